// File: rtl/inst_fetch_bridge_if.sv
// Bundles the CPU fetch handshake and the byte-wide memory read port of the
// instruction fetch bridge. Signal suffixes are named from the bridge's side.
interface inst_fetch_bridge_if;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        rom_valid_o;
  logic [31:0] mem_a_o;
  logic        mem_rd_o;
  logic [7:0]  mem_din_i;

  // Bridge side: accepts CPU requests, drives the memory address and strobe
  modport master (
    input  rom_ce_i,
    input  rom_addr_i,
    input  mem_din_i,
    output rom_data_o,
    output rom_valid_o,
    output mem_a_o,
    output mem_rd_o
  );

  // Environment side: the CPU and the byte memory together
  modport slave (
    output rom_ce_i,
    output rom_addr_i,
    output mem_din_i,
    input  rom_data_o,
    input  rom_valid_o,
    input  mem_a_o,
    input  mem_rd_o
  );
endinterface

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: turns a 32-bit word fetch from the CPU into four
// sequential byte reads from an 8-bit memory with one cycle of read latency,
// assembles the word little-endian and keeps the last completed word so a
// repeat fetch of the same word can be answered without touching memory.
module inst_fetch_bridge #(
  parameter bit HIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] base_q, base_d;
  logic [23:0] bytes_q, bytes_d;
  logic [31:0] romData_q, romData_d;
  logic        romValid_q, romValid_d;
  logic [31:0] memA_q, memA_d;
  logic        memRd_q, memRd_d;
  logic [31:0] tag_q, tag_d;
  logic        tagValid_q, tagValid_d;

  logic [31:0] reqBase;
  logic        hit;

  assign reqBase = {bus.rom_addr_i[31:2], 2'b00};
  assign hit     = HIT_EN && tagValid_q && (tag_q == reqBase);

  assign bus.rom_data_o  = romData_q;
  assign bus.rom_valid_o = romValid_q;
  assign bus.mem_a_o     = memA_q;
  assign bus.mem_rd_o    = memRd_q;

  // State register; reset parks the FSM in IDLE at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a dropped request aborts an in-flight fetch, a hit skips memory
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.rom_ce_i) begin
          state_d = hit ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.rom_ce_i) begin
          state_d = IDLE;
        end else if (k_q == 2'd3) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.rom_ce_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values of every registered output and datapath register; outputs are
  // computed one cycle ahead so they appear registered in the state they belong to
  always_comb begin
    k_d        = k_q;
    base_d     = base_q;
    bytes_d    = bytes_q;
    romData_d  = romData_q;
    romValid_d = 1'b0;
    memA_d     = memA_q;
    memRd_d    = memRd_q;
    tag_d      = tag_q;
    tagValid_d = tagValid_q;

    unique case (state_q)
      IDLE: begin
        memRd_d = 1'b0;
        if (bus.rom_ce_i) begin
          base_d = reqBase;
          k_d    = 2'd0;
          if (hit) begin
            romValid_d = 1'b1;
          end else begin
            memA_d  = reqBase;
            memRd_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (!bus.rom_ce_i) begin
          memRd_d = 1'b0;
          k_d     = 2'd0;
        end else begin
          case (k_q)
            2'd1:    bytes_d[7:0]   = bus.mem_din_i;
            2'd2:    bytes_d[15:8]  = bus.mem_din_i;
            2'd3:    bytes_d[23:16] = bus.mem_din_i;
            default: bytes_d        = bytes_q;
          endcase
          if (k_q == 2'd3) begin
            memRd_d = 1'b0;
            k_d     = 2'd0;
          end else begin
            k_d    = k_q + 2'd1;
            memA_d = base_q + 32'(k_q) + 32'd1;
          end
        end
      end
      DRAIN: begin
        memRd_d = 1'b0;
        k_d     = 2'd0;
        if (bus.rom_ce_i) begin
          romData_d  = {bus.mem_din_i, bytes_q};
          romValid_d = 1'b1;
          tag_d      = base_q;
          tagValid_d = 1'b1;
        end
      end
      DONE: begin
        memRd_d = 1'b0;
        k_d     = 2'd0;
      end
      default: begin
        memRd_d = 1'b0;
        k_d     = 2'd0;
      end
    endcase
  end

  // Datapath and output registers; reset clears partial bytes and the held word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q        <= 2'd0;
      base_q     <= 32'd0;
      bytes_q    <= 24'd0;
      romData_q  <= 32'd0;
      romValid_q <= 1'b0;
      memA_q     <= 32'd0;
      memRd_q    <= 1'b0;
      tag_q      <= 32'd0;
      tagValid_q <= 1'b0;
    end else begin
      k_q        <= k_d;
      base_q     <= base_d;
      bytes_q    <= bytes_d;
      romData_q  <= romData_d;
      romValid_q <= romValid_d;
      memA_q     <= memA_d;
      memRd_q    <= memRd_d;
      tag_q      <= tag_d;
      tagValid_q <= tagValid_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for the instruction fetch bridge: one instance with the hit
// path enabled, one with it disabled, each behind its own byte memory model.
module tb_inst_fetch_bridge;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  inst_fetch_bridge_if busA ();
  inst_fetch_bridge_if busB ();

  inst_fetch_bridge #(.HIT_EN(1'b1)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  inst_fetch_bridge #(.HIT_EN(1'b0)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte memory contents: two known words, a word at the top of the address space
  function automatic logic [7:0] memByte(input logic [31:0] a);
    case (a)
      32'h0000_0100: memByte = 8'h13;
      32'h0000_0101: memByte = 8'h05;
      32'h0000_0102: memByte = 8'h10;
      32'h0000_0103: memByte = 8'h00;
      32'h0000_0104: memByte = 8'h93;
      32'h0000_0105: memByte = 8'h00;
      32'h0000_0106: memByte = 8'h20;
      32'h0000_0107: memByte = 8'h00;
      32'hFFFF_FFFC: memByte = 8'hEF;
      32'hFFFF_FFFD: memByte = 8'hBE;
      32'hFFFF_FFFE: memByte = 8'hAD;
      32'hFFFF_FFFF: memByte = 8'hDE;
      default:       memByte = a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Memories answer one cycle after a strobed address
  always @(posedge clk) begin
    if (busA.mem_rd_o) busA.mem_din_i <= memByte(busA.mem_a_o);
    if (busB.mem_rd_o) busB.mem_din_i <= memByte(busB.mem_a_o);
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ceA, input logic ceB, input logic [31:0] addr);
    busA.rom_ce_i   = ceA;
    busB.rom_ce_i   = ceB;
    busA.rom_addr_i = addr;
    busB.rom_addr_i = addr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    #2;
    checkOutput("rst_data",  busA.rom_data_o,  32'h0);
    checkOutput("rst_valid", busA.rom_valid_o, 32'h0);
    checkOutput("rst_addr",  busA.mem_a_o,     32'h0);
    checkOutput("rst_rd",    busA.mem_rd_o,    32'h0);

    // Miss on 0x100, request presented together with reset release
    tick;
    tick;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h100);
    for (int i = 0; i < 4; i++) begin
      tick;
      checkOutput("miss_addr",    busA.mem_a_o,     32'h100 + 32'(i));
      checkOutput("miss_rd",      busA.mem_rd_o,    32'h1);
      checkOutput("miss_novalid", busA.rom_valid_o, 32'h0);
    end
    tick;
    checkOutput("miss_drain_rd",    busA.mem_rd_o,    32'h0);
    checkOutput("miss_drain_valid", busA.rom_valid_o, 32'h0);
    tick;
    checkOutput("miss_valid",   busA.rom_valid_o, 32'h1);
    checkOutput("miss_data",    busA.rom_data_o,  32'h0010_0513);
    checkOutput("miss_valid_b", busB.rom_valid_o, 32'h1);
    checkOutput("miss_data_b",  busB.rom_data_o,  32'h0010_0513);
    applyStimulus(1'b0, 1'b0, 32'h100);
    tick;
    checkOutput("miss_pulse_end", busA.rom_valid_o, 32'h0);
    checkOutput("miss_data_hold", busA.rom_data_o,  32'h0010_0513);

    // Repeat fetch 0x102: hit on A, full miss on B
    applyStimulus(1'b1, 1'b1, 32'h102);
    tick;
    checkOutput("hit_valid",    busA.rom_valid_o, 32'h1);
    checkOutput("hit_no_rd",    busA.mem_rd_o,    32'h0);
    checkOutput("hit_data",     busA.rom_data_o,  32'h0010_0513);
    checkOutput("nohit_rd_b",   busB.mem_rd_o,    32'h1);
    checkOutput("nohit_addr_b", busB.mem_a_o,     32'h100);
    checkOutput("nohit_val_b",  busB.rom_valid_o, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h102);
    tick;
    checkOutput("hit_pulse_end", busA.rom_valid_o, 32'h0);
    tick;
    tick;
    checkOutput("nohit_addr3_b", busB.mem_a_o, 32'h103);
    tick;
    checkOutput("nohit_c5_b", busB.rom_valid_o, 32'h0);
    tick;
    checkOutput("nohit_valid_b", busB.rom_valid_o, 32'h1);
    checkOutput("nohit_data_b",  busB.rom_data_o,  32'h0010_0513);
    applyStimulus(1'b0, 1'b0, 32'h102);
    tick;

    // Abort a fetch of 0x200 by dropping the request in cycle 3
    applyStimulus(1'b1, 1'b0, 32'h200);
    tick;
    checkOutput("abort_addr", busA.mem_a_o, 32'h200);
    tick;
    tick;
    applyStimulus(1'b0, 1'b0, 32'h200);
    tick;
    checkOutput("abort_rd",    busA.mem_rd_o,    32'h0);
    checkOutput("abort_valid", busA.rom_valid_o, 32'h0);
    checkOutput("abort_data",  busA.rom_data_o,  32'h0010_0513);
    for (int i = 0; i < 2; i++) begin
      tick;
      checkOutput("abort_novalid", busA.rom_valid_o, 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 32'h100);
    tick;
    checkOutput("abort_hit_valid", busA.rom_valid_o, 32'h1);
    checkOutput("abort_hit_rd",    busA.mem_rd_o,    32'h0);
    checkOutput("abort_hit_data",  busA.rom_data_o,  32'h0010_0513);
    applyStimulus(1'b0, 1'b0, 32'h100);
    tick;

    // Wrap at the top of the address space
    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) begin
      tick;
      checkOutput("wrap_addr", busA.mem_a_o, 32'hFFFF_FFFC + 32'(i));
    end
    tick;
    tick;
    checkOutput("wrap_valid", busA.rom_valid_o, 32'h1);
    checkOutput("wrap_data",  busA.rom_data_o,  32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick;

    // Asynchronous reset in cycle 2 of a fetch of 0x104
    applyStimulus(1'b1, 1'b0, 32'h104);
    tick;
    tick;
    checkOutput("rstmid_rd_before", busA.mem_rd_o, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_data",  busA.rom_data_o,  32'h0);
    checkOutput("rstmid_valid", busA.rom_valid_o, 32'h0);
    checkOutput("rstmid_addr",  busA.mem_a_o,     32'h0);
    checkOutput("rstmid_rd",    busA.mem_rd_o,    32'h0);
    tick;
    applyStimulus(1'b1, 1'b0, 32'h100);
    rst = 1'b0;
    tick;
    checkOutput("postrst_rd",    busA.mem_rd_o,    32'h1);
    checkOutput("postrst_addr",  busA.mem_a_o,     32'h100);
    checkOutput("postrst_valid", busA.rom_valid_o, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick;
    end
    checkOutput("postrst_done_valid", busA.rom_valid_o, 32'h1);
    checkOutput("postrst_done_data",  busA.rom_data_o,  32'h0010_0513);

    // Back-to-back: request held high, address moves on to 0x104
    applyStimulus(1'b1, 1'b0, 32'h104);
    tick;
    checkOutput("b2b_idle_valid", busA.rom_valid_o, 32'h0);
    tick;
    checkOutput("b2b_addr", busA.mem_a_o,  32'h104);
    checkOutput("b2b_rd",   busA.mem_rd_o, 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick;
    end
    checkOutput("b2b_c5_valid", busA.rom_valid_o, 32'h0);
    tick;
    checkOutput("b2b_valid", busA.rom_valid_o, 32'h1);
    checkOutput("b2b_data",  busA.rom_data_o,  32'h0020_0093);

    // Still held high on the same word: answered from the held word
    tick;
    checkOutput("held_idle_valid", busA.rom_valid_o, 32'h0);
    tick;
    checkOutput("held_hit_valid", busA.rom_valid_o, 32'h1);
    checkOutput("held_hit_rd",    busA.mem_rd_o,    32'h0);
    checkOutput("held_hit_data",  busA.rom_data_o,  32'h0020_0093);
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick;
    checkOutput("final_valid", busA.rom_valid_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
